// File: rtl/wcu_timer.sv
// wcu_timer: stage timer for the wash control unit.
//
// Turns the control unit's one-cycle restart strobe (tr) and stage code (ts) into
// a timed run measured in prescaled ticks, and returns a one-cycle cf pulse when
// the run expires. hold pauses counting; busy, remaining and stage feed the
// front-panel display.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   tr        in   start/restart strobe
//   ts        in   stage select (00 = no stage, start ignored)
//   hold      in   pause request while running
//   cf        out  one-cycle expiry pulse
//   busy      out  run in progress (RUN or HOLD)
//   remaining out  ticks left in the current run
//   stage     out  ts latched at the last accepted start
module wcu_timer #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned T_SHORT  = 2,
    parameter int unsigned T_WASH   = 30,
    parameter int unsigned T_SPIN   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tr,
    input  logic [1:0]       ts,
    input  logic             hold,
    output logic             cf,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       stage
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [PRE_W-1:0] prescale;
    logic [CNT_W-1:0] duration;
    logic             start;
    logic             tick;

    // ts = 00 is a no-op code, so a strobe carrying it is not a start.
    assign start = tr && (ts != 2'b00);
    assign tick  = (prescale == PRE_W'(TICK_DIV - 1));

    always_comb begin
        duration = '0;
        case (ts)
            2'b01:   duration = CNT_W'(T_SHORT);
            2'b10:   duration = CNT_W'(T_WASH);
            2'b11:   duration = CNT_W'(T_SPIN);
            default: duration = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            prescale  <= '0;
            remaining <= '0;
            stage     <= 2'b00;
        end else if (start) begin
            // Restart wins from any state; an aborted run never reaches DONE.
            state     <= S_RUN;
            prescale  <= '0;
            remaining <= duration;
            stage     <= ts;
        end else begin
            case (state)
                S_RUN, S_HOLD: begin
                    if (hold) begin
                        // Entry edge and every held edge leave the count frozen.
                        state <= S_HOLD;
                    end else begin
                        // The release edge counts like a normal run edge, so a
                        // pause costs exactly one cycle per held edge.
                        state <= S_RUN;
                        if (tick) begin
                            prescale <= '0;
                            if (remaining == CNT_W'(1)) begin
                                state     <= S_DONE;
                                remaining <= '0;
                            end else begin
                                remaining <= remaining - CNT_W'(1);
                            end
                        end else begin
                            prescale <= prescale + PRE_W'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cf   = (state == S_DONE);
    assign busy = (state == S_RUN) || (state == S_HOLD);

endmodule

// File: tb/tb_wcu_timer.sv
// Bench for wcu_timer: directed scenarios plus random stimulus, all outputs compared
// every cycle against a clock-count reference model.
module tb_wcu_timer;

    localparam int unsigned TD      = 4;
    localparam int unsigned CW      = 8;
    localparam int unsigned D_SHORT = 2;
    localparam int unsigned D_WASH  = 3;
    localparam int unsigned D_SPIN  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tr = 1'b0;
    logic [1:0]    ts = 2'b00;
    logic          hold = 1'b0;
    logic          cf;
    logic          busy;
    logic [CW-1:0] remaining;
    logic [1:0]    stage;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a run is a budget of clock cycles that shrinks by one on
    // every non-held edge; remaining ticks is that budget rounded up to ticks.
    bit         m_active = 0;
    bit         m_done   = 0;
    int         m_left   = 0;
    logic [1:0] m_stage  = 2'b00;

    wcu_timer #(
        .TICK_DIV (TD),
        .CNT_W    (CW),
        .T_SHORT  (D_SHORT),
        .T_WASH   (D_WASH),
        .T_SPIN   (D_SPIN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tr        (tr),
        .ts        (ts),
        .hold      (hold),
        .cf        (cf),
        .busy      (busy),
        .remaining (remaining),
        .stage     (stage)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ticks_for(input logic [1:0] code);
        case (code)
            2'b01:   return D_SHORT;
            2'b10:   return D_WASH;
            2'b11:   return D_SPIN;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        if (reset) begin
            m_active = 0;
            m_done   = 0;
            m_left   = 0;
            m_stage  = 2'b00;
        end else begin
            m_done = 0;
            if (tr && ts != 2'b00) begin
                m_active = 1;
                m_left   = ticks_for(ts) * TD;
                m_stage  = ts;
            end else if (m_active && !hold) begin
                m_left--;
                if (m_left == 0) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
    endtask

    // One clock: drive inputs on the falling edge, then compare after the rising edge.
    task automatic cyc(input logic r, input logic t, input logic [1:0] s, input logic h);
        @(negedge clk);
        reset = r;
        tr    = t;
        ts    = s;
        hold  = h;
        @(posedge clk);
        model_step();
        #1;
        check("cf", 32'(cf), 32'(m_done));
        check("busy", 32'(busy), 32'(m_active));
        check("remaining", 32'(remaining), m_active ? 32'((m_left + TD - 1) / TD) : 32'd0);
        check("stage", 32'(stage), 32'(m_stage));
    endtask

    initial begin
        int cf_at;
        int cf_cnt;

        // Reset state
        cyc(1, 0, 2'b00, 0);
        cyc(1, 1, 2'b10, 1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rem", 32'(remaining), 32'd0);
        check("rst_stage", 32'(stage), 32'd0);
        check("rst_cf", 32'(cf), 32'd0);

        // Ignored code in IDLE
        cyc(0, 1, 2'b00, 0);
        check("ign_idle_busy", 32'(busy), 32'd0);

        // Basic run: T_WASH = 3 ticks of 4 clocks
        cyc(0, 1, 2'b10, 0);
        check("basic_start_rem", 32'(remaining), 32'd3);
        check("basic_start_stage", 32'(stage), 32'd2);
        check("basic_start_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 13; k++) begin
            cyc(0, 0, 2'b00, 0);
            if (k == 3)  check("basic_rem_k3", 32'(remaining), 32'd3);
            if (k == 4)  check("basic_rem_k4", 32'(remaining), 32'd2);
            if (k == 8)  check("basic_rem_k8", 32'(remaining), 32'd1);
            if (k == 11) check("basic_cf_k11", 32'(cf), 32'd0);
            if (k == 12) check("basic_cf_k12", 32'(cf), 32'd1);
            if (k == 12) check("basic_rem_k12", 32'(remaining), 32'd0);
            if (k == 13) check("basic_cf_k13", 32'(cf), 32'd0);
            if (k == 13) check("basic_busy_k13", 32'(busy), 32'd0);
        end

        // Pause: hold for 5 edges from N+2 pushes cf to N+17
        cyc(0, 1, 2'b10, 0);
        cf_at = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, 2'b00, (k >= 2 && k <= 6));
            if (k == 6) check("pause_rem_frozen", 32'(remaining), 32'd3);
            if (cf && cf_at < 0) cf_at = k;
        end
        check("pause_cf_edge", 32'(cf_at), 32'd17);

        // Restart mid-run with T_SPIN at N+6; cf only at N+14
        cyc(0, 1, 2'b10, 0);
        cf_at  = -1;
        cf_cnt = 0;
        for (int k = 1; k <= 18; k++) begin
            if (k == 6) begin
                cyc(0, 1, 2'b11, 0);
                check("restart_rem", 32'(remaining), 32'd2);
                check("restart_stage", 32'(stage), 32'd3);
            end else begin
                cyc(0, 0, 2'b00, 0);
            end
            if (cf) begin
                cf_cnt++;
                if (cf_at < 0) cf_at = k;
            end
        end
        check("restart_cf_edge", 32'(cf_at), 32'd14);
        check("restart_cf_count", 32'(cf_cnt), 32'd1);

        // Ignored code mid-run
        cyc(0, 1, 2'b01, 0);
        cyc(0, 0, 2'b00, 0);
        cyc(0, 1, 2'b00, 0);
        check("ign_run_stage", 32'(stage), 32'd1);
        check("ign_run_busy", 32'(busy), 32'd1);

        // Start on the cf cycle: both the pulse and the new run stand
        for (int k = 0; k < 20 && !cf; k++) cyc(0, 0, 2'b00, 0);
        check("done_seen", 32'(cf), 32'd1);
        cyc(0, 1, 2'b10, 0);
        check("done_restart_busy", 32'(busy), 32'd1);
        check("done_restart_rem", 32'(remaining), 32'd3);

        // Reset mid-run: no cf for the aborted run
        cyc(0, 1, 2'b10, 0);
        cf_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc((k == 5), 0, 2'b00, 0);
            if (cf) cf_cnt++;
        end
        check("rstmid_cf_count", 32'(cf_cnt), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 24) == 0),
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
